// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus.
// Each output buffer raises its not_empty as a request. At most one buffer
// gets a one-hot cdb_permit in the same cycle. The highest-priority index
// (rr_ptr) moves one past the last winner, so a held request is served
// within N_REQ unsuppressed cycles. Per-requester wait counters back a
// sticky starvation_error flag that acts as a built-in fairness checker.
module cdb_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     request,
  input  logic                 cdb_hold,
  output logic [N_REQ-1:0]     cdb_permit,
  output logic                 cdb_active,
  output logic [IDX_WIDTH-1:0] grant_index,
  output logic                 starvation_error
);

  localparam int CNT_WIDTH = $clog2(N_REQ + 1);
  localparam logic [IDX_WIDTH:0]   N_EXT     = (IDX_WIDTH + 1)'(N_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(N_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(N_REQ);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(N_REQ - 1);

  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [CNT_WIDTH-1:0] wait_cnt [N_REQ];
  logic                 grant_valid;
  logic [IDX_WIDTH:0]   scan_pos;

  // Scan from rr_ptr upward with wrap; the first requester found wins.
  // scan_pos is one bit wider than an index so the wrap is a single subtract
  // and works for any N_REQ, not only powers of two.
  always_comb begin
    cdb_permit  = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    scan_pos    = '0;
    if (!reset && !cdb_hold) begin
      for (int off = 0; off < N_REQ; off++) begin
        scan_pos = {1'b0, rr_ptr} + (IDX_WIDTH + 1)'(off);
        if (scan_pos >= N_EXT) begin
          scan_pos = scan_pos - N_EXT;
        end
        if (!grant_valid && request[scan_pos[IDX_WIDTH-1:0]]) begin
          grant_valid                          = 1'b1;
          cdb_permit[scan_pos[IDX_WIDTH-1:0]] = 1'b1;
          grant_index                          = scan_pos[IDX_WIDTH-1:0];
        end
      end
    end
  end

  assign cdb_active = grant_valid;

  // Priority moves one past the winner; it holds when nothing was granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_index == LAST_IDX) ? '0 : grant_index + 1'b1;
    end
  end

  // Count cycles a requester waits without a permit. Held cycles are not
  // counted. Reaching N_REQ means the round-robin bound was broken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
      starvation_error <= 1'b0;
    end else if (!cdb_hold) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (request[i] && !cdb_permit[i]) begin
          if (wait_cnt[i] != CNT_MAX) begin
            wait_cnt[i] <= wait_cnt[i] + 1'b1;
          end
          if (wait_cnt[i] >= CNT_LIMIT) begin
            starvation_error <= 1'b1;
          end
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter (N_REQ=4): directed vectors with literal expectations,
// plus a round-robin model compared against the DUT on every cycle.
module tb_cdb_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic       cdb_hold;
  logic [3:0] cdb_permit;
  logic       cdb_active;
  logic [1:0] grant_index;
  logic       starvation_error;

  int checks = 0;
  int errors = 0;

  // Reference state: priority index, wait counts, starvation flag.
  int m_ptr = 0;
  int m_wait [N];
  bit m_starv = 1'b0;
  bit m_live  = 1'b0;

  cdb_arbiter #(.N_REQ(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .request          (request),
    .cdb_hold         (cdb_hold),
    .cdb_permit       (cdb_permit),
    .cdb_active       (cdb_active),
    .grant_index      (grant_index),
    .starvation_error (starvation_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner: the first requester at or after ptr, going round the ring.
  function automatic int model_grant(input logic [3:0] req, input int ptr);
    for (int off = 0; off < N; off++) begin
      int k;
      k = (ptr + off) % N;
      if (((int'(req) >> k) & 1) == 1) return k;
    end
    return -1;
  endfunction

  // Update the reference at each rising edge from the inputs of the cycle that is ending.
  always @(posedge clk) begin : model_update
    int g;
    int nw;
    if (reset) begin
      m_ptr   <= 0;
      m_starv <= 1'b0;
      m_live  <= 1'b1;
      for (int i = 0; i < N; i++) m_wait[i] <= 0;
    end else if (m_live && !cdb_hold) begin
      g = model_grant(request, m_ptr);
      if (g >= 0) m_ptr <= (g + 1) % N;
      for (int i = 0; i < N; i++) begin
        if ((((int'(request) >> i) & 1) == 1) && i != g) begin
          nw = (m_wait[i] + 1 > N) ? N : m_wait[i] + 1;
          m_wait[i] <= nw;
          if (nw == N) m_starv <= 1'b1;
        end else begin
          m_wait[i] <= 0;
        end
      end
    end
  end

  // Compare all outputs against the reference in the middle of every cycle.
  always @(negedge clk) begin : compare
    int g;
    logic [3:0] ep;
    logic [1:0] ei;
    if (m_live) begin
      g  = (reset || cdb_hold) ? -1 : model_grant(request, m_ptr);
      ep = (g < 0) ? 4'b0000 : 4'(1 << g);
      ei = (g < 0) ? 2'd0 : 2'(g);
      check("model_permit", 32'(cdb_permit), 32'(ep));
      check("model_active", 32'(cdb_active), 32'(g >= 0));
      check("model_index", 32'(grant_index), 32'(ei));
      check("model_starv", 32'(starvation_error), 32'(m_starv));
    end
  end

  // Apply inputs just after the rising edge, then wait until mid-cycle so
  // the caller can check the combinational outputs.
  task automatic step(input logic [3:0] r, input logic h, input logic rs);
    @(posedge clk);
    #1;
    request  = r;
    cdb_hold = h;
    reset    = rs;
    #3;
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  typedef struct { logic [3:0] r; logic h; } vec_t;
  vec_t vecs [10];

  int         rot [8];
  logic [4:0] bus_tag;
  logic       rs_waiting;
  logic [1:0] buf_valid;

  initial begin
    request  = 4'b0000;
    cdb_hold = 1'b0;
    reset    = 1'b1;

    // Reset with every buffer requesting: nothing is granted.
    step(4'b1111, 1'b0, 1'b1);
    check("reset_permit", 32'(cdb_permit), 32'h0);
    check("reset_active", 32'(cdb_active), 32'h0);
    step(4'b1111, 1'b0, 1'b1);
    check("reset_permit2", 32'(cdb_permit), 32'h0);

    // Rotation with all four requesting; the first grant after reset is index 0.
    rot = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      if (i == 0) check("first_after_reset", 32'(cdb_permit), 32'h1);
      check("rot_index", 32'(grant_index), 32'(rot[i]));
      check("rot_active", 32'(cdb_active), 32'h1);
    end
    check("rot_starv", 32'(starvation_error), 32'h0);

    // Skip and wrap: grant 1 moves the pointer to 2, then 0011 gives 0, 1, 0.
    step(4'b0010, 1'b0, 1'b0);
    check("skip_setup", 32'(grant_index), 32'd1);
    step(4'b0011, 1'b0, 1'b0);
    check("wrap_a", 32'(cdb_permit), 32'b0001);
    step(4'b0011, 1'b0, 1'b0);
    check("wrap_b", 32'(cdb_permit), 32'b0010);
    step(4'b0011, 1'b0, 1'b0);
    check("wrap_c", 32'(cdb_permit), 32'b0001);

    // Hold for three cycles, then the waiting request wins at once (pointer is 1).
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b1, 1'b0);
      check("hold_permit", 32'(cdb_permit), 32'h0);
      check("hold_index", 32'(grant_index), 32'h0);
    end
    step(4'b0100, 1'b0, 1'b0);
    check("after_hold", 32'(cdb_permit), 32'b0100);

    // The pointer (3 here) must not move while held, even with every buffer requesting.
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    check("hold_keeps_ptr", 32'(grant_index), 32'd3);

    // Idle: no grants and the pointer stays at 0.
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b0, 1'b0);
      check("idle_active", 32'(cdb_active), 32'h0);
      check("idle_index", 32'(grant_index), 32'h0);
    end
    step(4'b1000, 1'b0, 1'b0);
    check("idle_then_req", 32'(cdb_permit), 32'b1000);
    step(4'b1111, 1'b0, 1'b0);
    check("wrap_after_3", 32'(grant_index), 32'd0);

    // Reset and hold together: reset wins, so index 0 has priority afterwards.
    step(4'b1111, 1'b1, 1'b1);
    check("rst_hold_permit", 32'(cdb_permit), 32'h0);
    step(4'b1111, 1'b0, 1'b0);
    check("rst_hold_after", 32'(grant_index), 32'd0);

    // Reset mid-operation drops the grant that would have gone out.
    step(4'b1111, 1'b0, 1'b0);
    check("mid_pre", 32'(grant_index), 32'd1);
    step(4'b1111, 1'b0, 1'b1);
    check("mid_reset", 32'(cdb_active), 32'h0);
    step(4'b1111, 1'b0, 1'b0);
    check("mid_after", 32'(cdb_permit), 32'b0001);

    // Two buffers with ROB tags 19 (buffer 0) and 7 (buffer 1) become ready together.
    step(4'b0000, 1'b0, 1'b1);
    buf_valid  = 2'b11;
    rs_waiting = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step({2'b00, buf_valid}, 1'b0, 1'b0);
      bus_tag = cdb_permit[0] ? 5'd19 : (cdb_permit[1] ? 5'd7 : 5'd0);
      check((c == 0) ? "cdb_tag_first" : "cdb_tag_second", 32'(bus_tag), (c == 0) ? 32'd19 : 32'd7);
      if (c == 1) check("rs_woken", 32'(rs_waiting), 32'h0);
      @(posedge clk);
      if (bus_tag == 5'd19) rs_waiting = 1'b0;
      if (cdb_permit[0]) buf_valid[0] = 1'b0;
      if (cdb_permit[1]) buf_valid[1] = 1'b0;
      #0;
    end
    step({2'b00, buf_valid}, 1'b0, 1'b0);
    check("bufs_drained", 32'(cdb_active), 32'h0);

    // Mixed pattern table; the per-cycle model compare covers these.
    vecs = '{'{4'b1010, 1'b0}, '{4'b1010, 1'b0}, '{4'b0101, 1'b1}, '{4'b0110, 1'b0},
             '{4'b1111, 1'b0}, '{4'b1001, 1'b0}, '{4'b0001, 1'b0}, '{4'b0001, 1'b0},
             '{4'b1110, 1'b1}, '{4'b1110, 1'b0}};
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, vecs[i].h, 1'b0);
    end

    step(4'b0000, 1'b0, 1'b0);
    check("final_starv", 32'(starvation_error), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
